timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: cmd_valid  input  1  CPU presents a timer command.
REQ-004 SHALL have port: cmd_ready  output  1  block accepts command this cycle.
REQ-005 SHALL have port: cmd_op  input  2  00 TIME, 01 TIMERST, 10 WAIT, 11 reserved.
REQ-006 SHALL have port: cmd_arg  input  `WORD_BITS  WAIT duration in ms; ignored for other ops.
REQ-007 SHALL have port: ms_time  input  `WORD_BITS  ms count from the millisecond timer, mod 2^16.
REQ-008 SHALL have port: timer_rst  output  1  one-cycle reset request to the millisecond timer.
REQ-009 SHALL have port: resp_valid  output  1  response word available.
REQ-010 SHALL have port: resp_ready  input  1  CPU consumes the response.
REQ-011 SHALL have port: resp_data  output  `WORD_BITS  response word.
REQ-012 SHALL have port: resp_err  output  1  command was reserved or disabled.

Function
REQ-013 SHALL implement FSM states IDLE, RST, RST_SETTLE, WAIT, RESP.
REQ-014 SHALL assert cmd_ready only in IDLE; accept = cmd_valid && cmd_ready, at cycle N.
REQ-015 TIME SHALL latch ms_time at cycle N into resp_data and go to RESP; resp_valid high at N+1.
REQ-016 TIMERST SHALL go to RST; timer_rst high exactly at N+1; RST_SETTLE at N+2; resp_valid at N+3 with resp_data 0.
REQ-017 WAIT SHALL latch start = ms_time and dur = cmd_arg at N, then enter WAIT.
REQ-018 In WAIT, SHALL compute elapsed = (ms_time - start) mod 2^16, 16-bit wrap-around subtraction; go to RESP with resp_data = ms_time when elapsed >= dur.
REQ-019 WAIT with dur 0 SHALL produce resp_valid at N+2 (one WAIT compare cycle); response data is the ms_time at N+1.
REQ-020 WAIT SHALL span the 0xFFFF->0x0000 wrap correctly (start 0xFFFE, dur 3, completes when ms_time reaches 0x0001).
REQ-021 Reserved op SHALL go to RESP with resp_data 0xFFFF and resp_err 1; resp_valid at N+1.
REQ-022 resp_err SHALL be 0 for all valid ops.
REQ-023 In RESP, resp_valid, resp_data and resp_err SHALL be held stable until resp_ready; return to IDLE the cycle after resp_valid && resp_ready.
REQ-024 A new command SHALL not be accepted in the cycle the response is consumed; earliest next accept is the following cycle.
REQ-025 timer_rst SHALL be 0 in all states except RST.
REQ-026 An external ms_time discontinuity during WAIT (timer reset by other logic) SHALL be treated arithmetically per REQ-018, with no special case.

Reset
REQ-027 reset SHALL take priority over all other inputs in the same cycle.
REQ-028 On reset: state IDLE, cmd_ready 1 from the next cycle, resp_valid 0, resp_data 0, resp_err 0, timer_rst 0, start and dur 0.
REQ-029 Reset mid-WAIT or mid-RESP SHALL abort the command with no response; reset in RST SHALL drop timer_rst the next cycle.

Configuration
REQ-030 Macro TIMER_CTRL_WAIT_EN SHALL, when defined, compile in the WAIT op, the WAIT state, and the start/dur registers.
REQ-031 Without TIMER_CTRL_WAIT_EN, op 10 SHALL behave as reserved per REQ-021, and no WAIT registers SHALL exist.

Verification
REQ-032 TIME with ms_time=0x1234 at accept -> resp_valid the next cycle, resp_data 0x1234, resp_err 0.
REQ-033 TIMERST -> timer_rst high for exactly one cycle at N+1; resp_valid at N+3, resp_data 0x0000.
REQ-034 WAIT arg 5, start ms_time 0x0010 -> response when ms_time = 0x0015, resp_data 0x0015.
REQ-035 WAIT arg 3 at ms_time 0xFFFE -> response when ms_time = 0x0001.
REQ-036 Op 11, and op 10 with macro undefined -> resp_data 0xFFFF, resp_err 1; resp_ready held low 4 cycles -> outputs stable throughout.
REQ-037 reset asserted while in WAIT -> next cycle IDLE, resp_valid 0, cmd_ready 1, and no late response.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Command/response bus between the CPU (master) and timer_ctrl (slave).
// WORD_BITS sets the data word width and defaults to 16.
`ifndef WORD_BITS
`define WORD_BITS 16
`endif

interface timer_ctrl_if;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [`WORD_BITS-1:0]  cmd_arg;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [`WORD_BITS-1:0]  resp_data;
    logic                   resp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, resp_ready,
        input  cmd_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, resp_ready,
        output cmd_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/timer_ctrl.sv
// Timer command controller: TIME reads the ms counter, TIMERST pulses a
// reset to the ms counter, WAIT blocks until a duration has elapsed.
// Optional feature macro: TIMER_CTRL_WAIT_EN compiles in the WAIT op;
// without it op 10 is answered like the reserved op.
`ifndef WORD_BITS
`define WORD_BITS 16
`endif

module timer_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [`WORD_BITS-1:0] ms_time,
    output logic                  timer_rst,
    timer_ctrl_if.slave           bus
);
    localparam int W = `WORD_BITS;

`ifdef TIMER_CTRL_WAIT_EN
    typedef enum logic [2:0] {IDLE, RST, RST_SETTLE, WAIT, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, RST, RST_SETTLE, RESP} state_t;
`endif

    state_t         state;
    logic           cmd_ready_r;
    logic           resp_valid_r;
    logic [W-1:0]   resp_data_r;
    logic           resp_err_r;
    logic           timer_rst_r;

`ifdef TIMER_CTRL_WAIT_EN
    logic [W-1:0]   start;
    logic [W-1:0]   dur;
    logic [W-1:0]   elapsed;

    // Modular subtraction makes counter wrap and external resets of the
    // ms counter fall out of the arithmetic with no special case.
    assign elapsed = ms_time - start;
`else
    logic           unused_arg;
    assign unused_arg = ^bus.cmd_arg;
`endif

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_err   = resp_err_r;
    assign timer_rst      = timer_rst_r;

    // Control FSM with all outputs registered; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cmd_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_data_r  <= '0;
            resp_err_r   <= 1'b0;
            timer_rst_r  <= 1'b0;
`ifdef TIMER_CTRL_WAIT_EN
            start        <= '0;
            dur          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        case (bus.cmd_op)
                            2'b00: begin
                                resp_data_r  <= ms_time;
                                resp_err_r   <= 1'b0;
                                resp_valid_r <= 1'b1;
                                state        <= RESP;
                            end
                            2'b01: begin
                                timer_rst_r <= 1'b1;
                                state       <= RST;
                            end
`ifdef TIMER_CTRL_WAIT_EN
                            2'b10: begin
                                start <= ms_time;
                                dur   <= bus.cmd_arg;
                                state <= WAIT;
                            end
`endif
                            default: begin
                                resp_data_r  <= '1;
                                resp_err_r   <= 1'b1;
                                resp_valid_r <= 1'b1;
                                state        <= RESP;
                            end
                        endcase
                    end
                end
                RST: begin
                    timer_rst_r <= 1'b0;
                    state       <= RST_SETTLE;
                end
                RST_SETTLE: begin
                    resp_data_r  <= '0;
                    resp_err_r   <= 1'b0;
                    resp_valid_r <= 1'b1;
                    state        <= RESP;
                end
`ifdef TIMER_CTRL_WAIT_EN
                WAIT: begin
                    if (elapsed >= dur) begin
                        resp_data_r  <= ms_time;
                        resp_err_r   <= 1'b0;
                        resp_valid_r <= 1'b1;
                        state        <= RESP;
                    end
                end
`endif
                RESP: begin
                    // cmd_ready stays low in the consume cycle, so the next
                    // command can be taken one cycle later at the earliest.
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        cmd_ready_r  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cmd_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    timer_rst_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: a vector table of single commands plus
// hand-written reset and WAIT sequences.
module tb_timer_ctrl;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  ms_time;
    logic          timer_rst;

    timer_ctrl_if bus ();

    timer_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .ms_time   (ms_time),
        .timer_rst (timer_rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] arg;
        logic [W-1:0] ms;
        int           lat;
        logic [W-1:0] data;
        logic         err;
        int           hold;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and returns in cycle N+1 (just after the accept edge).
    task automatic issue(input logic [1:0] op, input logic [W-1:0] arg, input bit inc);
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_before_issue", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        tick();
        bus.cmd_valid = 1'b0;
        if (inc) ms_time = ms_time + 16'd1;
    endtask

    // Counts edges from accept until resp_valid; bounded by maxc.
    task automatic wait_resp(input int maxc, input bit inc, output int lat, output logic trst_n1,
                             output logic trst_late);
        lat       = 1;
        trst_n1   = timer_rst;
        trst_late = 1'b0;
        while (!bus.resp_valid && lat < maxc) begin
            tick();
            lat++;
            if (timer_rst) trst_late = 1'b1;
            if (inc) ms_time = ms_time + 16'd1;
        end
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("after_consume_valid_ready", {30'd0, bus.resp_valid, bus.cmd_ready}, 32'b01);
    endtask

    initial begin
        int   lat;
        logic t1, tl;
        bit   seen;

        vecs[0] = '{2'b00, 16'h0000, 16'h1234, 1, 16'h1234, 1'b0, 2};
        vecs[1] = '{2'b01, 16'h0000, 16'h4321, 3, 16'h0000, 1'b0, 2};
        vecs[2] = '{2'b11, 16'h0000, 16'h2222, 1, 16'hFFFF, 1'b1, 4};
`ifdef TIMER_CTRL_WAIT_EN
        vecs[3] = '{2'b10, 16'h0000, 16'h0777, 2, 16'h0777, 1'b0, 2};
`else
        vecs[3] = '{2'b10, 16'h0005, 16'h0777, 1, 16'hFFFF, 1'b1, 4};
`endif
        vecs[4] = '{2'b00, 16'h0000, 16'hFFFF, 1, 16'hFFFF, 1'b0, 1};
        vecs[5] = '{2'b00, 16'h0000, 16'h0000, 1, 16'h0000, 1'b0, 1};

        reset          = 1'b1;
        ms_time        = 16'h0000;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_arg    = '0;
        bus.resp_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_state", {12'd0, bus.cmd_ready, bus.resp_valid, bus.resp_err, timer_rst, bus.resp_data},
              {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});

        // Table of single commands.
        for (int i = 0; i < 6; i++) begin
            ms_time = vecs[i].ms;
            issue(vecs[i].op, vecs[i].arg, 1'b0);
            wait_resp(20, 1'b0, lat, t1, tl);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_data", i), {16'd0, bus.resp_data}, {16'd0, vecs[i].data});
            check($sformatf("v%0d_err", i), {31'd0, bus.resp_err}, {31'd0, vecs[i].err});
            check($sformatf("v%0d_timer_rst", i), {30'd0, t1, tl}, {30'd0, vecs[i].op == 2'b01, 1'b0});
            for (int h = 0; h < vecs[i].hold; h++) begin
                tick();
                check($sformatf("v%0d_hold%0d", i, h),
                      {13'd0, bus.resp_valid, bus.cmd_ready, bus.resp_err, bus.resp_data},
                      {13'd0, 1'b1, 1'b0, vecs[i].err, vecs[i].data});
            end
            consume();
        end

        // Back-to-back: accept on the cycle right after the consume.
        ms_time = 16'h0BEE;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        tick();
        bus.cmd_valid = 1'b0;
        check("b2b_accept", {15'd0, bus.resp_valid, bus.resp_data}, {15'd0, 1'b1, 16'h0BEE});
        consume();

        // Reset wins over a command presented in the same cycle.
        ms_time       = 16'h5555;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        reset         = 1'b1;
        tick();
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (bus.resp_valid) seen = 1'b1;
        end
        check("rst_priority", {30'd0, seen, bus.cmd_ready}, 32'b01);

        // Reset while a response is pending drops it.
        ms_time = 16'hABCD;
        issue(2'b00, 16'h0000, 1'b0);
        check("resp_pending", {31'd0, bus.resp_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_in_resp", {14'd0, bus.resp_valid, bus.cmd_ready, bus.resp_err, bus.resp_data},
              {14'd0, 1'b0, 1'b1, 1'b0, 16'h0000});

        // Reset while timer_rst is high drops it next cycle, no response later.
        issue(2'b01, 16'h0000, 1'b0);
        check("rst_pulse_high", {31'd0, timer_rst}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_in_rst", {30'd0, timer_rst, bus.cmd_ready}, 32'b01);
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (bus.resp_valid || timer_rst) seen = 1'b1;
        end
        check("rst_in_rst_quiet", {31'd0, seen}, 32'd0);

`ifdef TIMER_CTRL_WAIT_EN
        // WAIT 5 starting at 0x0010 with a running counter.
        ms_time = 16'h0010;
        issue(2'b10, 16'd5, 1'b1);
        wait_resp(30, 1'b1, lat, t1, tl);
        check("wait5_latency", lat, 6);
        check("wait5_data", {16'd0, bus.resp_data}, 32'h0015);
        check("wait5_err", {31'd0, bus.resp_err}, 32'd0);
        consume();

        // WAIT across the 16-bit wrap.
        ms_time = 16'hFFFE;
        issue(2'b10, 16'd3, 1'b1);
        wait_resp(30, 1'b1, lat, t1, tl);
        check("wrap_latency", lat, 4);
        check("wrap_data", {16'd0, bus.resp_data}, 32'h0001);
        consume();

        // Reset mid-WAIT aborts without a late response.
        ms_time = 16'h0000;
        issue(2'b10, 16'd8, 1'b1);
        repeat (3) begin
            tick();
            ms_time = ms_time + 16'd1;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_in_wait", {30'd0, bus.resp_valid, bus.cmd_ready}, 32'b01);
        seen = 1'b0;
        repeat (12) begin
            tick();
            ms_time = ms_time + 16'd1;
            if (bus.resp_valid) seen = 1'b1;
        end
        check("rst_in_wait_no_late", {31'd0, seen}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
